// File: rtl/vga_value_panel.sv
// On-screen decimal readout of NUM_CH live values: per-frame snapshot, sequential double-dabble
// conversion into a back buffer, atomic commit to the front buffer, 2-clk pixel pipeline.

module letter_gene #(
  parameter int W = 60,
  parameter int H = 100
) (
  input  logic [7:0] char_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       pix_o
);
  localparam int TW = W / 6;
  localparam int TH = H / 10;
  int x, y, d1, d2;

  always_comb begin
    x  = int'(x_i);
    y  = int'(y_i);
    d1 = x * H - y * W;
    d2 = x * H - (H - 1 - y) * W;
    if (d1 < 0) d1 = -d1;
    if (d2 < 0) d2 = -d2;
    pix_o = 1'b0;
    case (char_i)
      8'h20:   pix_o = 1'b0;
      8'h2D:   pix_o = (x >= TW) && (x < W - TW) && (y >= H/2 - TH/2) && (y < H/2 + TH/2);
      // colon cell is only DIGIT_GAP wide, so its dots span the full strip width
      8'h3A:   pix_o = ((y >= H/4 - TH) && (y < H/4 + TH)) ||
                       ((y >= 3*H/4 - TH) && (y < 3*H/4 + TH));
      8'h58:   pix_o = (d1 < TW * H) || (d2 < TW * H);
      default: pix_o = (x < TW) || (x >= W - TW) || (y < TH) || (y >= H - TH);
    endcase
  end
endmodule

module num_gen #(
  parameter int W = 60,
  parameter int H = 100
) (
  input  logic [3:0] dig_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       pix_o
);
  localparam int TW = W / 6;
  localparam int TH = H / 10;
  logic [6:0] seg;
  logic hx, vl, vr, up, lo;
  int x, y;

  always_comb begin
    x = int'(x_i);
    y = int'(y_i);
    case (dig_i) // {a,b,c,d,e,f,g}
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    hx = (x >= TW) && (x < W - TW);
    vl = (x < TW);
    vr = (x >= W - TW);
    up = (y >= TH/2) && (y < H/2);
    lo = (y >= H/2) && (y < H - TH/2);
    pix_o = (seg[6] && hx && (y < TH)) || (seg[5] && vr && up) || (seg[4] && vr && lo) ||
            (seg[3] && hx && (y >= H - TH)) || (seg[2] && vl && lo) || (seg[1] && vl && up) ||
            (seg[0] && hx && (y >= H/2 - TH/2) && (y < H/2 + TH/2));
  end
endmodule

module vga_value_panel #(
  parameter int          NUM_CH     = 3,
  parameter int          VAL_W      = 8,
  parameter int          NUM_DIG    = 3,
  parameter int          SIGNED     = 0,
  parameter int          BASE_X     = 50,
  parameter int          BASE_Y     = 50,
  parameter int          CELL_W     = 60,
  parameter int          CELL_H     = 100,
  parameter int          DIGIT_GAP  = 10,
  parameter int          LINE_PITCH = 120,
  parameter logic [11:0] FG_RGB     = 12'h000,
  parameter logic [11:0] BG_RGB     = 12'hFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [NUM_CH*VAL_W-1:0] values,
  input  logic [9:0]              counter_x,
  input  logic [9:0]              counter_y,
  input  logic                    in_display,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    busy,
  output logic                    digits_valid,
  output logic                    overrun
);
  function automatic int need_dig(input int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int i = 0; i < 8; i++) if (v > 0) begin n++; v = v / 10; end
    return n;
  endfunction

  if (NUM_DIG < need_dig(VAL_W)) begin : g_bad_dig
    $error("NUM_DIG too small for VAL_W");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH out of range");
  end

  localparam int BW    = NUM_DIG * 4;
  localparam int NCELL = NUM_DIG + ((SIGNED != 0) ? 1 : 0);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW  = $clog2(VAL_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_COMMIT} state_t;
  state_t state_q, state_d;

  logic [NUM_CH-1:0][VAL_W-1:0] snap_q, snap_d;
  logic [CHW-1:0]               ch_q, ch_d;
  logic [CNTW-1:0]              cnt_q, cnt_d;
  logic [BW-1:0]                bcd_q, bcd_d, adj;
  logic [VAL_W-1:0]             sh_q, sh_d, cur;
  logic                         sgn_q, sgn_d;
  logic [NUM_CH-1:0][BW-1:0]    back_dig_q, back_dig_d, front_dig_q, front_dig_d;
  logic [NUM_CH-1:0]            back_sgn_q, back_sgn_d, front_sgn_q, front_sgn_d;
  logic                         dv_q, dv_d, busy_q, ovr_q;

  always_comb begin
    state_d = state_q;  snap_d = snap_q;  ch_d = ch_q;  cnt_d = cnt_q;
    bcd_d = bcd_q;  sh_d = sh_q;  sgn_d = sgn_q;  dv_d = dv_q;
    back_dig_d = back_dig_q;  back_sgn_d = back_sgn_q;
    front_dig_d = front_dig_q;  front_sgn_d = front_sgn_q;
    cur = snap_q[ch_q];
    adj = bcd_q;
    for (int i = 0; i < NUM_DIG; i++)
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    unique case (state_q)
      S_IDLE: if (frame_start) begin
        snap_d  = values;
        ch_d    = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bcd_d   = '0;
        cnt_d   = '0;
        sgn_d   = (SIGNED != 0) && cur[VAL_W-1];
        sh_d    = sgn_d ? (~cur + 1'b1) : cur;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(VAL_W - 1)) state_d = S_STORE;
      end
      S_STORE: begin
        back_dig_d[ch_q] = bcd_q;
        back_sgn_d[ch_q] = sgn_q;
        if (ch_q == CHW'(NUM_CH - 1)) state_d = S_COMMIT;
        else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_COMMIT: begin
        front_dig_d = back_dig_q;
        front_sgn_d = back_sgn_q;
        dv_d        = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  snap_q <= '0;  ch_q <= '0;  cnt_q <= '0;
      bcd_q <= '0;  sh_q <= '0;  sgn_q <= 1'b0;  dv_q <= 1'b0;
      back_dig_q <= '0;  back_sgn_q <= '0;  front_dig_q <= '0;  front_sgn_q <= '0;
      busy_q <= 1'b0;  ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;  snap_q <= snap_d;  ch_q <= ch_d;  cnt_q <= cnt_d;
      bcd_q <= bcd_d;  sh_q <= sh_d;  sgn_q <= sgn_d;  dv_q <= dv_d;
      back_dig_q <= back_dig_d;  back_sgn_q <= back_sgn_d;
      front_dig_q <= front_dig_d;  front_sgn_q <= front_sgn_d;
      busy_q <= (state_d != S_IDLE);
      ovr_q  <= frame_start && (state_q != S_IDLE);
    end
  end

  assign busy         = busy_q;
  assign digits_valid = dv_q;
  assign overrun      = ovr_q;

  // Stage 1: locate the cell under the beam; reads the front buffer only
  logic        hit_s, dig_s, hit_q, dig_q, disp_q;
  logic [7:0]  code_s, code_q;
  logic [9:0]  bx_s, by_s, bx_q, by_q, cx_q, cy_q;
  logic [BW-1:0] row;
  int cxi, cyi, y0, x0;

  always_comb begin
    hit_s = 1'b0;  dig_s = 1'b0;  code_s = 8'h00;  bx_s = '0;  by_s = '0;
    row = '0;  y0 = 0;  x0 = 0;
    cxi = int'(counter_x);
    cyi = int'(counter_y);
    for (int r = 0; r < NUM_CH; r++) begin
      y0 = BASE_Y + r * LINE_PITCH;
      if (cyi >= y0 && cyi < y0 + CELL_H) begin
        by_s = 10'(y0);
        row  = front_dig_q[r];
        if (cxi >= BASE_X && cxi < BASE_X + CELL_W) begin
          hit_s = 1'b1;  code_s = 8'(8'h58 + r);  bx_s = 10'(BASE_X);
        end else if (cxi >= BASE_X + CELL_W && cxi < BASE_X + CELL_W + DIGIT_GAP) begin
          hit_s = 1'b1;  code_s = 8'h3A;  bx_s = 10'(BASE_X + CELL_W);
        end
        for (int k = 0; k < NCELL; k++) begin
          x0 = BASE_X + CELL_W + DIGIT_GAP + k * (CELL_W + DIGIT_GAP);
          if (cxi >= x0 && cxi < x0 + CELL_W) begin
            hit_s = 1'b1;
            bx_s  = 10'(x0);
            if (SIGNED != 0 && k == 0) code_s = front_sgn_q[r] ? 8'h2D : 8'h20;
            else begin
              dig_s  = 1'b1;
              code_s = {4'h0, 4'(row >> (4 * (NCELL - 1 - k)))};
            end
          end
        end
      end
    end
  end

  // Stage 2: glyph lookup and colour
  logic [9:0]  rx, ry;
  logic        let_pix, num_pix, glyph;
  logic [11:0] rgb_d, rgb_q;

  assign rx = cx_q - bx_q;
  assign ry = cy_q - by_q;

  letter_gene #(.W(CELL_W), .H(CELL_H)) u_let (.char_i(code_q), .x_i(rx), .y_i(ry), .pix_o(let_pix));
  num_gen     #(.W(CELL_W), .H(CELL_H)) u_num (.dig_i(code_q[3:0]), .x_i(rx), .y_i(ry), .pix_o(num_pix));

  assign glyph = dig_q ? num_pix : let_pix;
  assign rgb_d = (hit_q && glyph) ? FG_RGB : (disp_q ? BG_RGB : 12'h000);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;  dig_q <= 1'b0;  disp_q <= 1'b0;  code_q <= '0;
      bx_q <= '0;  by_q <= '0;  cx_q <= '0;  cy_q <= '0;  rgb_q <= '0;
    end else begin
      hit_q <= hit_s;  dig_q <= dig_s;  disp_q <= in_display;  code_q <= code_s;
      bx_q <= bx_s;  by_q <= by_s;  cx_q <= counter_x;  cy_q <= counter_y;  rgb_q <= rgb_d;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule
